comp2_serial_4bit: RTL
======================

COMP2_SERIAL_4BIT -- requirements
Module: comp2_serial_4bit

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning operand width in bits; only W=4 is supported.
REQ-002 The block SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, request to convert I; sampled only when ready=1.
REQ-005 The block SHALL have port I, input, 4, operand to negate; captured on the accepting edge.
REQ-006 The block SHALL have port ready, output, 1, high only in IDLE.
REQ-007 The block SHALL have port O, output, 4, two's complement of the last accepted I; registered.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse marking O newly valid.
REQ-009 The block SHALL have port ovf, output, 1, high with done when the operand was 1000 (-8 has no positive counterpart).

Function
REQ-010 The block SHALL implement a Moore FSM with states IDLE, SHIFT and DONE.
REQ-011 In IDLE with start=1, the block SHALL capture I into a 4-bit shift register, clear the bit counter and the seen-one flag, and enter SHIFT at that edge (edge k).
REQ-012 In SHIFT, each edge SHALL process one operand bit LSB-first: output bit = input bit XOR seen_one; seen_one then sets if the input bit was 1; the result bit shifts into the result register MSB-side.
REQ-013 SHIFT SHALL last exactly 4 edges (k+1..k+4), with a 2-bit counter wrapping 3->0 on the last bit and the FSM moving to DONE at edge k+4.
REQ-014 The FSM SHALL spend exactly one cycle in DONE and return to IDLE at edge k+5.
REQ-015 O SHALL load the completed result at edge k+4 and hold it until the next load.
REQ-016 done SHALL be high only in DONE.
REQ-017 ovf SHALL be high only in DONE and only when the operand was 1000; otherwise it SHALL be 0.
REQ-018 Result width SHALL be 4 bits, modulo 16: 0000->0000, 1000->1000, 0001->1111, 1111->0001.
REQ-019 start SHALL be ignored in SHIFT and DONE, and changes to I outside the accepting edge SHALL have no effect.
REQ-020 With start held high, a new conversion SHALL be accepted every 6 cycles, because the IDLE cycle is mandatory.
REQ-021 O SHALL keep its previous value throughout SHIFT, with no partial results visible.

Reset
REQ-022 rst=1 at any edge SHALL force: state IDLE, O=0000, done=0, ovf=0, counter=0, seen_one=0, shift/result registers=0, ready=1 in the following cycle.
REQ-023 Reset SHALL take priority over start at the same edge.
REQ-024 Reset mid-conversion SHALL abandon the conversion with no done pulse.

Structure
REQ-025 A shared package comp2_pkg SHALL hold the W constant, the FSM state type with its encodings (IDLE=00, SHIFT=01, DONE=10), and the overflow operand constant 1000.
REQ-026 One sub-module, comp2_bit_cell, SHALL hold the per-bit XOR and the seen-one flag register, with inputs clk, rst, clr, en, b_in and output b_out.
REQ-027 Encoding 11 SHALL be unreachable; if entered, the FSM SHALL return to IDLE at the next edge.

Verification
REQ-028 The bench SHALL check: I=0101, start pulse -> done high 5 cycles after the accepting edge, O=1011, ovf=0.
REQ-029 The bench SHALL check: I=1000 -> O=1000, ovf=1 with done; I=0000 -> O=0000, ovf=0.
REQ-030 The bench SHALL check: all 16 operands in turn -> O equals (16-I) mod 16 at each done, exactly one done per start.
REQ-031 The bench SHALL check: start pulsed and I changed during SHIFT -> ignored, result matches the originally captured I, ready=0 throughout.
REQ-032 The bench SHALL check: rst asserted at edge k+2 of a conversion -> no done, O=0000 next cycle, ready=1, and the next conversion is correct.
REQ-033 The bench SHALL check: start held high with I=0011 -> done every 6 cycles, O=1101 each time.

Source files
------------

// File: rtl/comp2_pkg.sv
// Shared constants and FSM state type for the serial two's-complement negator.
package comp2_pkg;

    localparam int unsigned W = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    localparam logic [W-1:0] OvfOperand = 4'b1000;

endpackage

// File: rtl/comp2_bit_cell.sv
// One serial negation step: out = in XOR seen_one, where seen_one latches the first 1 seen.
module comp2_bit_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic b_in,
    output logic b_out
);

    logic seen_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            seen_q <= 1'b0;
        end else if (en) begin
            seen_q <= seen_q | b_in;
        end
    end

    assign b_out = b_in ^ seen_q;

endmodule

// File: rtl/comp2_serial_4bit.sv
// Serial LSB-first two's-complement negator: IDLE -> 4 x SHIFT -> DONE -> IDLE.
module comp2_serial_4bit #(
    parameter int unsigned W = comp2_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] I,
    output logic         ready,
    output logic [W-1:0] O,
    output logic         done,
    output logic         ovf
);

    import comp2_pkg::*;

    state_e       state_q;
    logic [W-1:0] shift_q;
    logic [W-1:0] result_q;
    logic [W-1:0] o_q;
    logic [1:0]   cnt_q;
    logic         done_q;
    logic         ovf_q;

    logic         accept;
    logic         shifting;
    logic         bit_out;
    logic [W-1:0] result_next;

    assign accept      = (state_q == StIdle) && start;
    assign shifting    = (state_q == StShift);
    assign result_next = {bit_out, result_q[W-1:1]};

    comp2_bit_cell u_bit_cell (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (shifting),
        .b_in  (shift_q[0]),
        .b_out (bit_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            result_q <= '0;
            o_q      <= '0;
            cnt_q    <= 2'd0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        shift_q <= I;
                        cnt_q   <= 2'd0;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    shift_q  <= shift_q >> 1;
                    result_q <= result_next;
                    cnt_q    <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        o_q     <= result_next;
                        done_q  <= 1'b1;
                        // Negation is a bijection, so a 1000 result implies a 1000 operand.
                        ovf_q   <= (result_next == OvfOperand);
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ready = (state_q == StIdle);
    assign O     = o_q;
    assign done  = done_q;
    assign ovf   = ovf_q;

endmodule
